// File: rtl/zbt_pattern_checker_pkg.sv
// zbt_pattern_checker_pkg
//   Shared constants, types and helpers for the ZBT test-pattern checker
//   and its companion writer.
//   - LOG_ADDR / LOG_MEM: ZBT address and data widths.
//   - ZBT_ON0_HALF / ZBT_ON1_HALF / ZBT_OFF_HALF: 18-bit halves of the
//     checkerboard words; every 36-bit word is one half duplicated.
//   - state_t: checker FSM states.
//   - address_calculator: maps (x, y, loc) to a ZBT word address. The two
//     frame locations are 640x480 regions stacked back to back.
package zbt_pattern_checker_pkg;

    localparam int LOG_ADDR = 20;
    localparam int LOG_MEM  = 36;

    localparam logic [17:0] ZBT_ON0_HALF = 18'b111111111100011000;
    localparam logic [17:0] ZBT_ON1_HALF = 18'b111111111000010000;
    localparam logic [17:0] ZBT_OFF_HALF = 18'b000000001000010000;

    localparam int FRAME_H = 640;
    localparam int FRAME_V = 480;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SCAN0,
        ST_SCAN1,
        ST_DRAIN,
        ST_DONE
    } state_t;

    function automatic logic [LOG_ADDR-1:0] address_calculator(
        input logic [9:0] x,
        input logic [9:0] y,
        input logic       loc
    );
        logic [LOG_ADDR-1:0] base;
        base = loc ? LOG_ADDR'(FRAME_H * FRAME_V) : '0;
        return base + LOG_ADDR'(y) * LOG_ADDR'(FRAME_H) + LOG_ADDR'(x);
    endfunction

endpackage

// File: rtl/zbt_pattern_checker_if.sv
// zbt_pattern_checker_if
//   Two-bank ZBT memory bus.
//   - mem0_addr / mem1_addr : word address per bank
//   - mem0_wr / mem1_wr     : write enable per bank
//   - mem0_read / mem1_read : read data per bank
//   master: the pattern checker/writer side. slave: the memory side.
interface zbt_pattern_checker_if;
    import zbt_pattern_checker_pkg::*;

    logic [LOG_ADDR-1:0] mem0_addr;
    logic [LOG_ADDR-1:0] mem1_addr;
    logic                mem0_wr;
    logic                mem1_wr;
    logic [LOG_MEM-1:0]  mem0_read;
    logic [LOG_MEM-1:0]  mem1_read;

    modport master (
        output mem0_addr, mem1_addr, mem0_wr, mem1_wr,
        input  mem0_read, mem1_read
    );

    modport slave (
        input  mem0_addr, mem1_addr, mem0_wr, mem1_wr,
        output mem0_read, mem1_read
    );

endinterface

// File: rtl/zbt_pattern_checker_expect.sv
// zbt_pattern_expect
//   Combinational checkerboard generator shared by the writer and checker.
//   - x, y      : pixel coordinates
//   - sel_bit   : square size select; 0 uses bit 4, 1 uses bit 5
//   - mem0_word : expected bank 0 word
//   - mem1_word : expected bank 1 word
module zbt_pattern_expect
    import zbt_pattern_checker_pkg::*;
(
    input  logic [9:0]         x,
    input  logic [9:0]         y,
    input  logic               sel_bit,
    output logic [LOG_MEM-1:0] mem0_word,
    output logic [LOG_MEM-1:0] mem1_word
);

    logic on;

    always_comb begin
        on        = sel_bit ? (x[5] ^ y[5]) : (x[4] ^ y[4]);
        mem0_word = on ? {ZBT_ON0_HALF, ZBT_ON0_HALF} : {ZBT_OFF_HALF, ZBT_OFF_HALF};
        mem1_word = on ? {ZBT_ON1_HALF, ZBT_ON1_HALF} : {ZBT_OFF_HALF, ZBT_OFF_HALF};
    end

endmodule

// File: rtl/zbt_pattern_checker.sv
// zbt_pattern_checker
//   Reads back both ZBT banks over frame locations 0 and 1 and compares
//   against the expected checkerboard.
//   Ports:
//   - clock, reset : system clock, synchronous active-high reset
//   - start        : begin a sweep (only honoured in IDLE)
//   - mem          : ZBT bus (master side); writes are held off
//   - busy         : sweep in progress, through the DONE cycle
//   - done         : one-cycle pulse at sweep end
//   - pass         : valid at done; 1 iff no mismatching pixel
//   - err_count    : mismatching pixels, saturating at 16'hFFFF
//   - first_err_addr / first_err_loc : address and location of first mismatch
//   Build option: ZBT_CHECK_STOP_EN stops the sweep at the first mismatch.
module zbt_pattern_checker
    import zbt_pattern_checker_pkg::*;
#(
    parameter int unsigned READ_LATENCY = 2,
    parameter int unsigned H_PIXELS     = 640,
    parameter int unsigned V_PIXELS     = 480
)(
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    zbt_pattern_checker_if.master mem,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [15:0]           err_count,
    output logic [LOG_ADDR-1:0]   first_err_addr,
    output logic [1:0]            first_err_loc
);

    localparam logic [9:0] X_LAST = 10'(H_PIXELS - 1);
    localparam logic [9:0] Y_LAST = 10'(V_PIXELS - 1);

    state_t              state, state_next;
    logic [9:0]          x, y, x_next, y_next;
    logic                loc, loc_next;
    logic [2:0]          drain_cnt;
    logic [LOG_ADDR-1:0] addr;
    logic                scan;
    logic                err_hit;
    logic                stop_now;
    logic [LOG_MEM-1:0]  exp0, exp1;

    // Delay line aligning each issued address with its returned data.
    logic                dly_valid [READ_LATENCY];
    logic [LOG_MEM-1:0]  dly_exp0  [READ_LATENCY];
    logic [LOG_MEM-1:0]  dly_exp1  [READ_LATENCY];
    logic [LOG_ADDR-1:0] dly_addr  [READ_LATENCY];
    logic                dly_loc   [READ_LATENCY];

    // x/y/loc always describe the address currently on the bus.
    zbt_pattern_expect u_expect (
        .x         (x),
        .y         (y),
        .sel_bit   (loc),
        .mem0_word (exp0),
        .mem1_word (exp1)
    );

    assign scan    = (state == ST_SCAN0) || (state == ST_SCAN1);
    assign err_hit = dly_valid[READ_LATENCY-1] &&
                     ((mem.mem0_read != dly_exp0[READ_LATENCY-1]) ||
                      (mem.mem1_read != dly_exp1[READ_LATENCY-1]));

`ifdef ZBT_CHECK_STOP_EN
    assign stop_now = err_hit;
`else
    assign stop_now = 1'b0;
`endif

    assign mem.mem0_addr = addr;
    assign mem.mem1_addr = addr;
    assign mem.mem0_wr   = 1'b0;
    assign mem.mem1_wr   = 1'b0;
    assign busy          = (state != ST_IDLE);
    assign done          = (state == ST_DONE);

    always_comb begin
        state_next = state;
        x_next     = x;
        y_next     = y;
        loc_next   = loc;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_next = ST_SCAN0;
                    x_next     = '0;
                    y_next     = '0;
                    loc_next   = 1'b0;
                end
            end
            ST_SCAN0, ST_SCAN1: begin
                if (x == X_LAST) begin
                    x_next = '0;
                    y_next = y + 10'd1;
                end else begin
                    x_next = x + 10'd1;
                end
                if ((x == X_LAST) && (y == Y_LAST)) begin
                    y_next = '0;
                    if (state == ST_SCAN0) begin
                        state_next = ST_SCAN1;
                        loc_next   = 1'b1;
                    end else begin
                        state_next = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (drain_cnt == 3'(READ_LATENCY - 1)) state_next = ST_DONE;
            end
            ST_DONE:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
        if (stop_now) state_next = ST_DRAIN;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state          <= ST_IDLE;
            x              <= '0;
            y              <= '0;
            loc            <= 1'b0;
            drain_cnt      <= '0;
            addr           <= '0;
            pass           <= 1'b0;
            err_count      <= '0;
            first_err_addr <= '0;
            first_err_loc  <= '0;
            for (int unsigned i = 0; i < READ_LATENCY; i++) dly_valid[i] <= 1'b0;
        end else begin
            state <= state_next;
            x     <= x_next;
            y     <= y_next;
            loc   <= loc_next;

            if ((state_next == ST_SCAN0) || (state_next == ST_SCAN1))
                addr <= address_calculator(x_next, y_next, loc_next);

            // A stop during DRAIN restarts the full drain window.
            if ((state_next == ST_DRAIN) && ((state != ST_DRAIN) || stop_now))
                drain_cnt <= '0;
            else if (state == ST_DRAIN)
                drain_cnt <= drain_cnt + 3'd1;

            dly_valid[0] <= scan;
            for (int unsigned i = 1; i < READ_LATENCY; i++) dly_valid[i] <= dly_valid[i-1];
            // Reads still in flight after a stop must not be scored.
            if (stop_now)
                for (int unsigned i = 0; i < READ_LATENCY; i++) dly_valid[i] <= 1'b0;

            if ((state == ST_IDLE) && start) begin
                err_count      <= '0;
                first_err_addr <= '0;
                first_err_loc  <= '0;
                pass           <= 1'b0;
            end else if (err_hit) begin
                if (err_count != '1) err_count <= err_count + 16'd1;
                if (err_count == '0) begin
                    first_err_addr <= dly_addr[READ_LATENCY-1];
                    first_err_loc  <= {1'b0, dly_loc[READ_LATENCY-1]};
                end
            end

            // The last compare shares the edge that enters DONE.
            if (state_next == ST_DONE) pass <= (err_count == '0) && !err_hit;
        end
    end

    always_ff @(posedge clock) begin
        dly_exp0[0] <= exp0;
        dly_exp1[0] <= exp1;
        dly_addr[0] <= addr;
        dly_loc[0]  <= loc;
        for (int unsigned i = 1; i < READ_LATENCY; i++) begin
            dly_exp0[i] <= dly_exp0[i-1];
            dly_exp1[i] <= dly_exp1[i-1];
            dly_addr[i] <= dly_addr[i-1];
            dly_loc[i]  <= dly_loc[i-1];
        end
    end

endmodule

// File: tb/tb_zbt_pattern_checker.sv
// tb_zbt_pattern_checker
//   Directed bench. A small-frame instance (64x4) covers timing, fault
//   reporting and control; a 256x128 instance on zero-filled banks runs
//   concurrently to reach err_count saturation.
module tb_zbt_pattern_checker;
    import zbt_pattern_checker_pkg::*;

    localparam int LAT       = 2;
    localparam int HS        = 64;
    localparam int VS        = 4;
    localparam int HB        = 256;
    localparam int VB        = 128;
    localparam int SWEEP_LAT = 2 * HS * VS + LAT + 1;  // 515
    localparam int BIG_LAT   = 2 * HB * VB + LAT + 1;  // 65539
`ifdef ZBT_CHECK_STOP_EN
    localparam bit STOP_EN = 1'b1;
`else
    localparam bit STOP_EN = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_s, start_s, busy_s, done_s, pass_s;
    logic [15:0] err_s;
    logic [LOG_ADDR-1:0] fea_s;
    logic [1:0] fel_s;
    logic rst_b, start_b, busy_b, done_b, pass_b;
    logic [15:0] err_b;
    logic [LOG_ADDR-1:0] fea_b;
    logic [1:0] fel_b;

    zbt_pattern_checker_if bus_s ();
    zbt_pattern_checker_if bus_b ();

    zbt_pattern_checker #(.READ_LATENCY(LAT), .H_PIXELS(HS), .V_PIXELS(VS)) u_dut_s (
        .clock(clk), .reset(rst_s), .start(start_s), .mem(bus_s),
        .busy(busy_s), .done(done_s), .pass(pass_s), .err_count(err_s),
        .first_err_addr(fea_s), .first_err_loc(fel_s)
    );

    zbt_pattern_checker #(.READ_LATENCY(LAT), .H_PIXELS(HB), .V_PIXELS(VB)) u_dut_b (
        .clock(clk), .reset(rst_b), .start(start_b), .mem(bus_b),
        .busy(busy_b), .done(done_b), .pass(pass_b), .err_count(err_b),
        .first_err_addr(fea_b), .first_err_loc(fel_b)
    );

    int total = 0;
    int bad   = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int tb_addr(input int x, input int y, input int loc);
        return loc * 307200 + y * 640 + x;
    endfunction

    // Bank model: decode the address back to (x, y, loc) and build the word.
    function automatic logic [35:0] bank_word(input int bank, input int a);
        int lc, rem, px, py, b;
        logic on;
        logic [17:0] half;
        lc  = (a >= 307200) ? 1 : 0;
        rem = a - lc * 307200;
        py  = rem / 640;
        px  = rem % 640;
        b   = (lc == 1) ? 5 : 4;
        on  = (((px >> b) ^ (py >> b)) & 1) != 0;
        if (!on)            half = 18'b000000001000010000;
        else if (bank == 0) half = 18'b111111111100011000;
        else                half = 18'b111111111000010000;
        return {half, half};
    endfunction

    logic fault0_en = 1'b0, fault1_en = 1'b0;
    int   fault0_addr = 0, fault1_addr = 0;
    logic [35:0] r0_1, r1_1;

    // Two register stages give READ_LATENCY = 2.
    always @(posedge clk) begin
        r0_1 <= (fault0_en && int'(bus_s.mem0_addr) == fault0_addr) ? 36'd0
                : bank_word(0, int'(bus_s.mem0_addr));
        r1_1 <= (fault1_en && int'(bus_s.mem1_addr) == fault1_addr) ? 36'd0
                : bank_word(1, int'(bus_s.mem1_addr));
        bus_s.mem0_read <= r0_1;
        bus_s.mem1_read <= r1_1;
    end

    assign bus_b.mem0_read = '0;
    assign bus_b.mem1_read = '0;

    task automatic run_sweep(input int repulse_at, output int lat,
                             output logic [31:0] a2, output logic [31:0] a65,
                             output logic [31:0] a257, output logic b1);
        int n;
        @(posedge clk); #1 start_s = 1'b1;
        @(posedge clk); #1 start_s = 1'b0;
        n = 1; lat = -1; a2 = '0; a65 = '0; a257 = '0; b1 = 1'b0;
        while (n <= SWEEP_LAT + 20) begin
            @(negedge clk);
            if (n == 1)   b1   = busy_s;
            if (n == 2)   a2   = 32'(bus_s.mem0_addr);
            if (n == 65)  a65  = 32'(bus_s.mem0_addr);
            if (n == 257) a257 = 32'(bus_s.mem1_addr);
            start_s = (n == repulse_at);
            if (done_s) begin
                lat = n;
                break;
            end
            n++;
        end
        start_s = 1'b0;
        if (lat < 0) check_val("sweep_timeout", 32'd0, 32'd1);
    endtask

    logic sat_done = 1'b0;

    // Saturation run on the large instance, concurrent with the main tests.
    initial begin
        int n, lat;
        rst_b = 1'b1; start_b = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_b = 1'b0;
        @(posedge clk); #1 start_b = 1'b1;
        @(posedge clk); #1 start_b = 1'b0;
        n = 1; lat = -1;
        while (n <= BIG_LAT + 20) begin
            @(negedge clk);
            if (done_b) begin
                lat = n;
                break;
            end
            n++;
        end
        check_val("sat_latency", 32'(lat), 32'(BIG_LAT));
        check_val("sat_err", 32'(err_b), 32'h0000FFFF);
        check_val("sat_pass", 32'(pass_b), 32'd0);
        check_val("sat_first_loc", 32'(fel_b), 32'd0);
        check_val("sat_first_addr", 32'(fea_b), 32'd0);
        sat_done = 1'b1;
    end

    initial begin
        int lat, dn;
        logic [31:0] a2, a65, a257;
        logic b1;
        rst_s = 1'b1; start_s = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_s = 1'b0;
        @(negedge clk);
        check_val("rst_busy", 32'(busy_s), 32'd0);
        check_val("rst_done", 32'(done_s), 32'd0);
        check_val("rst_pass", 32'(pass_s), 32'd0);
        check_val("rst_err", 32'(err_s), 32'd0);
        check_val("rst_addr0", 32'(bus_s.mem0_addr), 32'd0);
        check_val("rst_addr1", 32'(bus_s.mem1_addr), 32'd0);
        check_val("rst_wr0", 32'(bus_s.mem0_wr), 32'd0);
        check_val("rst_wr1", 32'(bus_s.mem1_wr), 32'd0);
        check_val("rst_fea", 32'(fea_s), 32'd0);
        check_val("rst_fel", 32'(fel_s), 32'd0);

        // Clean pass
        run_sweep(0, lat, a2, a65, a257, b1);
        check_val("clean_latency", 32'(lat), 32'(SWEEP_LAT));
        check_val("clean_busy_c1", 32'(b1), 32'd1);
        check_val("clean_addr_c2", a2, 32'(tb_addr(1, 0, 0)));
        check_val("clean_addr_c65", a65, 32'(tb_addr(0, 1, 0)));
        check_val("clean_addr1_c257", a257, 32'(tb_addr(0, 0, 1)));
        check_val("clean_pass", 32'(pass_s), 32'd1);
        check_val("clean_err", 32'(err_s), 32'd0);
        @(negedge clk);
        check_val("clean_done_pulse", 32'(done_s), 32'd0);
        check_val("clean_busy_after", 32'(busy_s), 32'd0);
        check_val("clean_pass_hold", 32'(pass_s), 32'd1);

        // Single bank-0 fault at loc 0 (17,0)
        fault0_en = 1'b1; fault0_addr = tb_addr(17, 0, 0);
        run_sweep(0, lat, a2, a65, a257, b1);
        check_val("single_latency", 32'(lat), STOP_EN ? 32'(1 + 17 + 2 * LAT + 1) : 32'(SWEEP_LAT));
        check_val("single_err", 32'(err_s), 32'd1);
        check_val("single_pass", 32'(pass_s), 32'd0);
        check_val("single_fel", 32'(fel_s), 32'd0);
        check_val("single_fea", 32'(fea_s), 32'(tb_addr(17, 0, 0)));
        fault0_en = 1'b0;

        // Both banks corrupted at loc 1 (0,0)
        fault0_en = 1'b1; fault0_addr = tb_addr(0, 0, 1);
        fault1_en = 1'b1; fault1_addr = tb_addr(0, 0, 1);
        run_sweep(0, lat, a2, a65, a257, b1);
        check_val("dual_err", 32'(err_s), 32'd1);
        check_val("dual_pass", 32'(pass_s), 32'd0);
        check_val("dual_fel", 32'(fel_s), 32'd1);
        check_val("dual_fea", 32'(fea_s), 32'(tb_addr(0, 0, 1)));
        fault0_en = 1'b0; fault1_en = 1'b0;

        // Bank 0 at loc 0 (5,3) then bank 1 at loc 1 (0,0): first error latched once
        fault0_en = 1'b1; fault0_addr = tb_addr(5, 3, 0);
        fault1_en = 1'b1; fault1_addr = tb_addr(0, 0, 1);
        run_sweep(0, lat, a2, a65, a257, b1);
        check_val("two_latency", 32'(lat), STOP_EN ? 32'(1 + 197 + 2 * LAT + 1) : 32'(SWEEP_LAT));
        check_val("two_err", 32'(err_s), STOP_EN ? 32'd1 : 32'd2);
        check_val("two_fel", 32'(fel_s), 32'd0);
        check_val("two_fea", 32'(fea_s), 32'(tb_addr(5, 3, 0)));
        fault0_en = 1'b0; fault1_en = 1'b0;

        // start re-pulsed during SCAN1 is ignored
        run_sweep(300, lat, a2, a65, a257, b1);
        check_val("repulse_latency", 32'(lat), 32'(SWEEP_LAT));
        check_val("repulse_pass", 32'(pass_s), 32'd1);

        // Reset mid-SCAN1 aborts with no done pulse
        fault0_en = 1'b1; fault0_addr = tb_addr(17, 0, 0);
        @(posedge clk); #1 start_s = 1'b1;
        @(posedge clk); #1 start_s = 1'b0;
        repeat (300) @(negedge clk);
        check_val("abort_err_before", 32'(err_s), 32'd1);
        rst_s = 1'b1;
        @(posedge clk); #1 rst_s = 1'b0;
        fault0_en = 1'b0;
        @(negedge clk);
        check_val("abort_busy", 32'(busy_s), 32'd0);
        check_val("abort_err", 32'(err_s), 32'd0);
        check_val("abort_fea", 32'(fea_s), 32'd0);
        check_val("abort_addr", 32'(bus_s.mem0_addr), 32'd0);
        check_val("abort_pass", 32'(pass_s), 32'd0);
        dn = 0;
        repeat (600) begin
            @(negedge clk);
            if (done_s) dn++;
        end
        check_val("abort_no_done", 32'(dn), 32'd0);

        // Following start completes a clean pass
        run_sweep(0, lat, a2, a65, a257, b1);
        check_val("after_abort_latency", 32'(lat), 32'(SWEEP_LAT));
        check_val("after_abort_pass", 32'(pass_s), 32'd1);
        check_val("after_abort_err", 32'(err_s), 32'd0);

        wait (sat_done);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
